// File: rtl/mult_thread_arb.sv
// mult_thread_arb: round-robin sharing of the mul/div unit across threads with mul shadow pipe, div ownership and per-thread flush
module mult_thread_arb #(
  parameter int NUM_THREADS = 2,
  parameter int TID_W       = 1,
  parameter int MUL_LAT     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_THREADS-1:0] req_valid_i,
  input  logic [NUM_THREADS-1:0] req_is_div_i,
  output logic [NUM_THREADS-1:0] req_ready_o,
  input  logic [NUM_THREADS-1:0] flush_i,
  output logic                   unit_valid_o,
  output logic [TID_W-1:0]       unit_sel_o,
  output logic                   unit_flush_o,
  input  logic                   unit_div_ready_i,
  input  logic                   unit_res_valid_i,
  input  logic [TID_W-1:0]       unit_res_thread_i,
  output logic [NUM_THREADS-1:0] res_valid_o
);
  logic [TID_W-1:0]       rr_ptr_q, div_owner_q, gnt_idx, hi_idx, lo_idx, head_tid;
  logic                   div_busy_q, kill_cycle, gnt, hi_any, div_gnt, mul_gnt, mul_res, div_res;
  logic [NUM_THREADS-1:0] elig;
  logic [MUL_LAT-1:0]     occ_q, live_q;
  logic [TID_W-1:0]       tid_q [MUL_LAT];
  assign kill_cycle = div_busy_q & flush_i[div_owner_q];
  always_comb begin
    elig = '0;
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    for (int t = NUM_THREADS-1; t >= 0; t--) begin
      elig[t] = req_valid_i[t] & ~flush_i[t] & ~kill_cycle & (~req_is_div_i[t] | (~div_busy_q & unit_div_ready_i));
      if (elig[t]) begin
        lo_idx = TID_W'(t);
        if (t >= int'(rr_ptr_q)) begin
          hi_idx = TID_W'(t);
          hi_any = 1'b1;
        end
      end
    end
  end
  assign gnt      = |elig;
  assign gnt_idx  = hi_any ? hi_idx : lo_idx;
  assign div_gnt  = gnt & req_is_div_i[gnt_idx];
  assign mul_gnt  = gnt & ~req_is_div_i[gnt_idx];
  assign head_tid = tid_q[MUL_LAT-1];
  assign mul_res  = unit_res_valid_i & occ_q[MUL_LAT-1];
  assign div_res  = unit_res_valid_i & ~occ_q[MUL_LAT-1];
  assign unit_valid_o = gnt & ~rst_i;
  assign unit_sel_o   = rst_i ? '0 : gnt_idx;
  assign unit_flush_o = kill_cycle & ~rst_i;
  always_comb begin
    req_ready_o = '0;
    res_valid_o = '0;
    if (gnt & ~rst_i) req_ready_o[gnt_idx] = 1'b1;
    if (mul_res & ~rst_i) res_valid_o[head_tid] = live_q[MUL_LAT-1] & ~flush_i[head_tid];
    else if (div_res & ~rst_i) res_valid_o[div_owner_q] = div_busy_q & ~kill_cycle;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      div_busy_q  <= 1'b0;
      div_owner_q <= '0;
      occ_q       <= '0;
      live_q      <= '0;
    end else begin
      if (gnt) rr_ptr_q <= (int'(gnt_idx) == NUM_THREADS-1) ? '0 : gnt_idx + 1'b1;
      if (div_gnt) begin
        div_busy_q  <= 1'b1;
        div_owner_q <= gnt_idx;
      end else if (kill_cycle | (div_res & div_busy_q)) div_busy_q <= 1'b0;
      occ_q[0]  <= mul_gnt;
      live_q[0] <= mul_gnt & ~flush_i[gnt_idx];
      tid_q[0]  <= gnt_idx;
      for (int k = 1; k < MUL_LAT; k++) begin
        occ_q[k]  <= occ_q[k-1];
        live_q[k] <= live_q[k-1] & ~flush_i[tid_q[k-1]];
        tid_q[k]  <= tid_q[k-1];
      end
    end
  end
  always_ff @(posedge clk_i)
    if (!rst_i && (mul_res || (div_res && div_busy_q)))
      assert (unit_res_thread_i == (mul_res ? head_tid : div_owner_q));
endmodule

// File: tb/tb_mult_thread_arb.sv
// tb_mult_thread_arb: randomized and directed checks of mult_thread_arb against a queue-based behavioural model
module tb_mult_thread_arb;
  localparam int N = 2;
  localparam int L = 2;
  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid, req_is_div, req_ready, flush, res_valid;
  logic         unit_valid, unit_flush, div_ready, unit_res_valid;
  logic [0:0]   unit_sel, unit_res_thread;
  mult_thread_arb #(.NUM_THREADS(N), .TID_W(1), .MUL_LAT(L)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_is_div_i(req_is_div),
    .req_ready_o(req_ready), .flush_i(flush), .unit_valid_o(unit_valid), .unit_sel_o(unit_sel),
    .unit_flush_o(unit_flush), .unit_div_ready_i(div_ready), .unit_res_valid_i(unit_res_valid),
    .unit_res_thread_i(unit_res_thread), .res_valid_o(res_valid)
  );
  always #5 clk = ~clk;
  typedef struct {int due; int tid; bit live;} mul_t;
  mul_t         mq[$];
  int           cyc, rr, owner, dv_cnt, dv_len, checks, errors;
  bit           busy, dv_act;
  logic [N-1:0] cap_ready, cap_res;
  logic         cap_uflush, cap_uvalid;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask
  task automatic step(input logic [N-1:0] rv, input logic [N-1:0] rd, input logic [N-1:0] fl, input bit r, input bit drdy);
    bit           mul_due, div_pres, kill;
    int           g;
    logic [N-1:0] elig, exp_ready, exp_res;
    mul_due  = mq.size() > 0 && mq[0].due == cyc;
    div_pres = dv_act && dv_cnt == 0 && !mul_due;
    req_valid = rv;
    req_is_div = rd;
    flush = fl;
    rst = r;
    div_ready = !dv_act && drdy;
    unit_res_valid = mul_due || div_pres;
    unit_res_thread = mul_due ? 1'(mq[0].tid) : div_pres ? 1'(owner) : 1'($urandom);
    #1;
    kill = busy && fl[owner];
    for (int t = 0; t < N; t++)
      elig[t] = rv[t] && !fl[t] && !kill && (!rd[t] || (!busy && div_ready));
    g = -1;
    for (int i = 0; i < N; i++)
      if (g < 0 && elig[(rr + i) % N]) g = (rr + i) % N;
    exp_ready = g >= 0 ? N'(1 << g) : '0;
    exp_res = '0;
    if (mul_due) begin
      if (mq[0].live && !fl[mq[0].tid]) exp_res[mq[0].tid] = 1'b1;
    end else if (div_pres && busy && !kill) exp_res[owner] = 1'b1;
    cap_ready = req_ready;
    cap_res = res_valid;
    cap_uflush = unit_flush;
    cap_uvalid = unit_valid;
    check("req_ready", 32'(req_ready), r ? 32'd0 : 32'(exp_ready));
    check("unit_valid", 32'(unit_valid), (r || g < 0) ? 32'd0 : 32'd1);
    check("unit_sel", 32'(unit_sel), (r || g < 0) ? 32'd0 : 32'(g));
    check("unit_flush", 32'(unit_flush), r ? 32'd0 : 32'(kill));
    check("res_valid", 32'(res_valid), r ? 32'd0 : 32'(exp_res));
    @(posedge clk);
    #1;
    if (r) begin
      rr = 0;
      busy = 0;
      owner = 0;
      dv_act = 0;
      mq.delete();
    end else begin
      if (mul_due) void'(mq.pop_front());
      foreach (mq[i]) if (fl[mq[i].tid]) mq[i].live = 0;
      if (div_pres || kill) begin
        dv_act = 0;
        busy = 0;
      end
      if (dv_act && dv_cnt > 0) dv_cnt--;
      if (g >= 0) begin
        rr = (g + 1) % N;
        if (rd[g]) begin
          busy = 1;
          owner = g;
          dv_act = 1;
          dv_cnt = dv_len > 0 ? dv_len : int'($urandom_range(0, 6));
        end else mq.push_back('{cyc + L, g, 1'b1});
      end
    end
    cyc++;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && (busy || mq.size() > 0); i++) step('0, '0, '0, 0, 1);
    check("drain_timeout", 32'(busy || mq.size() > 0), 32'd0);
  endtask
  initial begin
    logic [N-1:0] rv, rd, fl, pat;
    checks = 0;
    errors = 0;
    cyc = 0;
    dv_len = 3;
    rr = 0;
    busy = 0;
    owner = 0;
    dv_act = 0;
    step(2'b11, 2'b01, 2'b00, 1, 1);
    step(2'b11, 2'b00, 2'b00, 1, 1);
    check("reset_outputs", {cap_ready, cap_res, cap_uvalid, cap_uflush}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(i < 6 ? 2'b11 : 2'b00, 2'b00, 2'b00, 0, 1);
      pat = (i % 2) ? 2'b10 : 2'b01;
      if (i < 6) check("rr_grant", 32'(cap_ready), 32'(pat));
      if (i >= 2) check("rr_result", 32'(cap_res), 32'(pat));
    end
    step(2'b01, 2'b01, 2'b00, 0, 1);
    check("div_grant_t0", 32'(cap_ready), 32'h1);
    step(2'b10, 2'b00, 2'b00, 0, 1);
    check("mul_while_div", 32'(cap_ready), 32'h2);
    step(2'b10, 2'b10, 2'b00, 0, 1);
    check("div_blocked_a", 32'(cap_ready), 32'h0);
    step(2'b10, 2'b10, 2'b00, 0, 1);
    check("div_blocked_b", 32'(cap_ready), 32'h0);
    check("mul_res_over_div", 32'(cap_res), 32'h2);
    step(2'b10, 2'b10, 2'b00, 0, 1);
    check("div_blocked_c", 32'(cap_ready), 32'h0);
    check("div_result_t0", 32'(cap_res), 32'h1);
    step(2'b10, 2'b10, 2'b00, 0, 1);
    check("div_grant_t1", 32'(cap_ready), 32'h2);
    drain();
    step(2'b01, 2'b00, 2'b00, 0, 1);
    check("iso_grant_t0", 32'(cap_ready), 32'h1);
    step(2'b10, 2'b00, 2'b01, 0, 1);
    check("iso_grant_t1", 32'(cap_ready), 32'h2);
    step(2'b00, 2'b00, 2'b00, 0, 1);
    check("iso_t0_dropped", 32'(cap_res), 32'h0);
    step(2'b00, 2'b00, 2'b00, 0, 1);
    check("iso_t1_kept", 32'(cap_res), 32'h2);
    drain();
    dv_len = 5;
    step(2'b01, 2'b01, 2'b00, 0, 1);
    check("abort_div_grant", 32'(cap_ready), 32'h1);
    step(2'b00, 2'b00, 2'b00, 0, 1);
    step(2'b10, 2'b00, 2'b01, 0, 1);
    check("abort_uflush", 32'(cap_uflush), 32'h1);
    check("abort_no_grant", 32'(cap_ready), 32'h0);
    step(2'b10, 2'b10, 2'b00, 0, 1);
    check("abort_regrant", 32'(cap_ready), 32'h2);
    check("abort_no_res", 32'(cap_res), 32'h0);
    check("abort_uflush_one", 32'(cap_uflush), 32'h0);
    drain();
    step(2'b01, 2'b01, 2'b00, 0, 1);
    step(2'b11, 2'b00, 2'b00, 0, 1);
    step(2'b11, 2'b00, 2'b00, 0, 1);
    step(2'b11, 2'b00, 2'b00, 1, 1);
    check("rst_mid_zero", {cap_ready, cap_res, cap_uvalid, cap_uflush}, 32'd0);
    step(2'b11, 2'b00, 2'b00, 1, 1);
    check("rst_mid_zero2", {cap_ready, cap_res, cap_uvalid, cap_uflush}, 32'd0);
    step(2'b11, 2'b00, 2'b00, 0, 1);
    check("rst_first_t0", 32'(cap_ready), 32'h1);
    step(2'b00, 2'b00, 2'b00, 0, 1);
    check("rst_no_stale", 32'(cap_res), 32'h0);
    step(2'b00, 2'b00, 2'b00, 0, 1);
    check("rst_new_mul", 32'(cap_res), 32'h1);
    dv_len = 0;
    for (int i = 0; i < 3000; i++) begin
      rv = N'($urandom);
      for (int t = 0; t < N; t++) begin
        rd[t] = ($urandom % 4) == 0;
        fl[t] = ($urandom % 12) == 0;
      end
      step(rv, rd, fl, ($urandom % 250) == 0, ($urandom % 4) != 0);
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
